fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer directly downstream of the instruction fetch unit; it feeds the decode stage.
- Decouples fetch from decode with a valid/ready handshake on both sides.
- Stores {pc, instr} pairs in a circular FIFO and presents the head word plus pre-split MIPS fields to decode.
- Supports a synchronous flush on branch/jump redirect.

Parameters:
DEPTH, 4, number of entries; must be a power of two, at least 2
PTR_W, 2, log2(DEPTH); width of the read and write pointers

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  fetch presents a word
in_ready  output  1  queue can accept a word this cycle
in_pc  input  32  PC of the incoming word
in_instr  input  32  incoming instruction
flush  input  1  synchronous discard of all entries (redirect)
out_valid  output  1  head word is valid
out_ready  input  1  decode consumes the head this cycle
out_pc  output  32  PC of the head word
out_instr  output  32  head instruction
out_opcode  output  6  out_instr[31:26]
out_rs  output  5  out_instr[25:21]
out_rt  output  5  out_instr[20:16]
out_rd  output  5  out_instr[15:11]
out_shamt  output  5  out_instr[10:6]
out_func  output  6  out_instr[5:0]
out_imm  output  16  out_instr[15:0]
out_imm26  output  26  out_instr[25:0]
count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_pc=0, out_instr=0, so all field outputs are 0.
  - Storage contents are don't-care.
- Handshakes: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is independent of out_ready, so there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- First-word-fall-through: out_pc and out_instr come combinationally from entry rd_ptr when count != 0.
- When count == 0, out_pc=0 and out_instr=32'h0000_0000 (MIPS nop), so decode sees a nop on bubbles.
- Latency: a word pushed at edge N is visible on out_* after edge N (1 cycle) when the queue was empty.
- On push: mem[wr_ptr] <= {in_pc, in_instr}; wr_ptr <= wr_ptr+1. Pointers wrap modulo DEPTH by natural PTR_W overflow.
- On pop: rd_ptr <= rd_ptr+1 with the same wrap rule.
- count updates:
  - push only: +1
  - pop only: -1
  - push & pop together: unchanged, and both pointers advance.
- Full (count == DEPTH): in_ready=0, so in_valid is ignored. A pop in the same cycle frees a slot for the next cycle only.
- Empty (count == 0): pop is impossible because out_valid=0.
- Flush has the highest priority:
  - At the next edge: wr_ptr=rd_ptr=0, count=0.
  - A push or pop in the same cycle is discarded and does not take effect.
  - out_valid=0 in the following cycle.
- Flush while reset=0: reset dominates.
- FIFO order is strict: words leave in push order. pc values are not checked or modified.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN
- Defined:
  - When count == 0 and in_valid=1, out_valid=1 with out_pc=in_pc and out_instr=in_instr combinationally (zero latency).
  - If out_ready=1 in that cycle, the word is consumed and not written into storage; count stays 0.
  - If out_ready=0, the word is stored normally.
  - flush=1 suppresses the bypass (out_valid=0).
- Not defined: empty-queue latency is 1 cycle, as described above.

Test Plan:
- Reset released. Push pc 0x3000 / instr 0x3c010000 with out_ready=0 -> next cycle out_valid=1, out_pc=0x3000, out_opcode=0x0f, out_rt=1, count=1.
- Push 4 words 0x3000..0x300c with out_ready=0 -> count=4 and in_ready=0. A 5th push of 0x3010 is ignored. Drain all -> out_pc sequence is 0x3000, 0x3004, 0x3008, 0x300c, then out_valid=0 and out_instr=0.
- At count=2, hold in_valid=out_ready=1 for 10 cycles with incrementing PCs -> count stays 2, pointers wrap, and output order matches push order.
- At count=3, assert flush together with a push of 0x4000 -> next cycle count=0 and out_valid=0. The following push of 0x4004 appears next at the head, and 0x4000 never appears.
- Assert reset=0 asynchronously mid-cycle with count=2 -> out_valid drops immediately, count=0.
- With FETCHQ_BYPASS_EN and an empty queue, drive in_valid=1, out_ready=1, pc 0x3000 -> out_valid=1 and out_pc=0x3000 in the same cycle, and count remains 0.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Fetch-to-decode instruction buffer. Circular FIFO of
//               {pc, instr} pairs with first-word-fall-through head, MIPS
//               field split, and synchronous redirect flush.
//               Optional macro FETCHQ_BYPASS_EN: zero-latency empty-queue bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_pc,
    input  logic [31:0]        in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_instr,
    output logic [5:0]         out_opcode,
    output logic [4:0]         out_rs,
    output logic [4:0]         out_rt,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_shamt,
    output logic [5:0]         out_func,
    output logic [15:0]        out_imm,
    output logic [25:0]        out_imm26,
    output logic [PTR_W:0]     count
);

    localparam logic [PTR_W:0]   c_FULL    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   c_CNT_ONE = (PTR_W + 1)'(1);

    if ((DEPTH < 2) || (DEPTH != (1 << PTR_W))) begin : g_param_check
        $error("fetch_queue: DEPTH must be a power of two >= 2 and equal 2**PTR_W");
    end

    logic [31:0]      r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_bypass_vld;
    logic             w_bypass_take;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [PTR_W:0]   w_count_nxt;
    logic [31:0]      w_head_pc;
    logic [31:0]      w_head_instr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);

`ifdef FETCHQ_BYPASS_EN
    // An empty queue forwards the incoming word straight to decode; if decode
    // takes it the word never touches storage.
    assign w_bypass_vld  = w_empty & in_valid & ~flush;
    assign w_bypass_take = w_bypass_vld & out_ready;
`else
    assign w_bypass_vld  = 1'b0;
    assign w_bypass_take = 1'b0;
`endif

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty | w_bypass_vld;

    // Flush wins over both handshakes; a consumed bypass word is neither
    // written nor popped.
    assign w_wr_en = in_valid & ~w_full & ~w_bypass_take & ~flush;
    assign w_rd_en = out_valid & out_ready & ~w_empty & ~flush;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // Storage carries no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_pc[r_wr_ptr]    <= in_pc;
            r_mem_instr[r_wr_ptr] <= in_instr;
        end
    end

    assign w_head_pc    = r_mem_pc[r_rd_ptr];
    assign w_head_instr = r_mem_instr[r_rd_ptr];

    // Bubbles present pc 0 and a nop so decode never sees stale data.
    always_comb begin
        out_pc    = 32'h0000_0000;
        out_instr = 32'h0000_0000;
        if (!w_empty) begin
            out_pc    = w_head_pc;
            out_instr = w_head_instr;
        end else if (w_bypass_vld) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end

    assign out_opcode = out_instr[31:26];
    assign out_rs     = out_instr[25:21];
    assign out_rt     = out_instr[20:16];
    assign out_rd     = out_instr[15:11];
    assign out_shamt  = out_instr[10:6];
    assign out_func   = out_instr[5:0];
    assign out_imm    = out_instr[15:0];
    assign out_imm26  = out_instr[25:0];
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue: queue-based reference
//               model, per-cycle compare process, directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic [31:0]       in_instr;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
    logic [5:0]        out_opcode;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [4:0]        out_shamt;
    logic [5:0]        out_func;
    logic [15:0]       out_imm;
    logic [25:0]       out_imm26;
    logic [PTR_W:0]    count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    word_t q[$];

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_func(out_func), .out_imm(out_imm), .out_imm26(out_imm26),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mdl_bypass();
`ifdef FETCHQ_BYPASS_EN
        return (q.size() == 0) && in_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: a plain queue of accepted words.
    always @(posedge clk or negedge reset) begin
        bit    acc;
        bit    take;
        word_t w;
        if (!reset) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            acc  = in_valid && (q.size() < DEPTH);
            take = out_ready && ((q.size() != 0) || mdl_bypass());
            if (!(take && q.size() == 0)) begin
                if (take) void'(q.pop_front());
                if (acc) begin
                    w.pc    = in_pc;
                    w.instr = in_instr;
                    q.push_back(w);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [31:0] exp_in;
        if (chk_en) begin
            exp_v  = (q.size() != 0) || mdl_bypass();
            exp_pc = (q.size() != 0) ? q[0].pc    : (mdl_bypass() ? in_pc    : 32'h0);
            exp_in = (q.size() != 0) ? q[0].instr : (mdl_bypass() ? in_instr : 32'h0);
            chk("in_ready",  128'(in_ready),  128'(q.size() < DEPTH));
            chk("out_valid", 128'(out_valid), 128'(exp_v));
            chk("count",     128'(count),     128'(q.size()));
            chk("out_pc",    128'(out_pc),    128'(exp_pc));
            chk("out_instr", 128'(out_instr), 128'(exp_in));
            chk("fields",
                128'({out_opcode, out_rs, out_rt, out_rd, out_shamt, out_func, out_imm, out_imm26}),
                128'({exp_in[31:26], exp_in[25:21], exp_in[20:16], exp_in[15:11],
                      exp_in[10:6], exp_in[5:0], exp_in[15:0], exp_in[25:0]}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        in_pc    = 32'h0;
        in_instr = 32'h0;
        idle();
        repeat (3) tick();
        reset  = 1'b1;
        chk_en = 1'b1;
        chk("rst out_valid", 128'(out_valid), 128'(0));
        chk("rst count",     128'(count),     128'(0));
        chk("rst out_instr", 128'(out_instr), 128'(0));
        chk("rst in_ready",  128'(in_ready),  128'(1));

        // First word: lui $1 -> opcode 0x0f, rt 1
        push(32'h3000, 32'h3c01_0000);
        chk("lat out_valid", 128'(out_valid),  128'(1));
        chk("lat out_pc",    128'(out_pc),     128'(32'h3000));
        chk("lat opcode",    128'(out_opcode), 128'(6'h0f));
        chk("lat rt",        128'(out_rt),     128'(5'd1));
        chk("lat count",     128'(count),      128'(1));
        drain(1);

        // Fill, overflow attempt, drain in order
        for (int i = 0; i < 4; i++) push(32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
        chk("full count",    128'(count),    128'(4));
        chk("full in_ready", 128'(in_ready), 128'(0));
        push(32'h3010, 32'hdead_beef);
        chk("ovf count",     128'(count),    128'(4));
        for (int i = 0; i < 4; i++) begin
            chk("drain pc", 128'(out_pc), 128'(32'h3000 + 32'(4 * i)));
            drain(1);
        end
        chk("empty out_valid", 128'(out_valid), 128'(0));
        chk("empty out_instr", 128'(out_instr), 128'(0));

        // Steady streaming at occupancy 2 with pointer wrap
        push(32'h5000, 32'h2000_0000);
        push(32'h5004, 32'h2000_0001);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_pc    = 32'h5008 + 32'(4 * i);
            in_instr = 32'h2000_0002 + 32'(i);
            tick();
        end
        idle();
        chk("stream count",   128'(count),  128'(2));
        chk("stream head pc", 128'(out_pc), 128'(32'h5028));
        drain(2);

        // Flush with concurrent push
        push(32'h6000, 32'h0);
        push(32'h6004, 32'h0);
        push(32'h6008, 32'h0);
        flush = 1'b1;
        push(32'h4000, 32'h2400_4000);
        flush = 1'b0;
        chk("flush count",     128'(count),     128'(0));
        chk("flush out_valid", 128'(out_valid), 128'(0));
        push(32'h4004, 32'h2400_4004);
        chk("post flush pc",    128'(out_pc), 128'(32'h4004));
        chk("post flush count", 128'(count),  128'(1));
        drain(1);

        // Asynchronous reset mid-cycle
        push(32'h7000, 32'h0);
        push(32'h7004, 32'h0);
        @(posedge clk);
        #4;
        reset = 1'b0;
        #1;
        chk("arst out_valid", 128'(out_valid), 128'(0));
        chk("arst count",     128'(count),     128'(0));
        chk("arst out_pc",    128'(out_pc),    128'(0));
        tick();
        reset = 1'b1;

`ifdef FETCHQ_BYPASS_EN
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_pc     = 32'h3000;
        in_instr  = 32'h3c01_0000;
        #1;
        chk("byp out_valid", 128'(out_valid), 128'(1));
        chk("byp out_pc",    128'(out_pc),    128'(32'h3000));
        tick();
        idle();
        chk("byp count",     128'(count),     128'(0));
`endif

        // Random traffic with phases biased toward full, empty and balanced
        for (int i = 0; i < 3000; i++) begin
            int phase;
            phase     = (i / 250) % 3;
            in_valid  = ($urandom_range(0, 3) < (phase == 1 ? 1 : 3));
            out_ready = ($urandom_range(0, 3) < (phase == 0 ? 1 : (phase == 1 ? 3 : 2)));
            flush     = ($urandom_range(0, 19) == 0);
            in_pc     = $urandom;
            in_instr  = $urandom;
            tick();
        end
        idle();
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
